// File: rtl/pulse_arbiter.sv
// Latches per-source event pulses into sticky pending bits and hands them out one per
// valid/ready handshake, round-robin, flagging lost events; 2-cycle pulse-to-valid, index held under backpressure.
module pulse_arbiter #(
    parameter int PULSE_COUNT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PULSE_COUNT-1:0] pulses,
    input  logic [PULSE_COUNT-1:0] mask,
    input  logic                   clear,
    output logic                   valid,
    input  logic                   ready,
    output logic [7:0]             index,
    output logic [PULSE_COUNT-1:0] pending,
    output logic [PULSE_COUNT-1:0] overflow
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [PULSE_COUNT-1:0] pending_q;
    logic [PULSE_COUNT-1:0] overflow_q;
    logic [PULSE_COUNT-1:0] capture;
    logic [PULSE_COUNT-1:0] grant_vec;
    logic [7:0]             index_q;
    logic [7:0]             last_q;
    logic [7:0]             grant_idx;
    logic [7:0]             hi_idx;
    logic [7:0]             lo_idx;
    logic                   lo_hit;
    logic                   any_pending;
    logic                   do_grant;

    assign capture     = pulses & mask;
    assign any_pending = |pending_q;

    // Descending search from last-1 with wrap: prefer the highest pending bit below
    // last, otherwise the highest pending bit overall.
    always_comb begin : grant_search
        hi_idx = '0;
        lo_idx = '0;
        lo_hit = 1'b0;
        for (int i = 0; i < PULSE_COUNT; i++) begin
            if (pending_q[i]) begin
                hi_idx = 8'(i);
                if (8'(i) < last_q) begin
                    lo_idx = 8'(i);
                    lo_hit = 1'b1;
                end
            end
        end
        grant_idx = lo_hit ? lo_idx : hi_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d  = state_q;
        do_grant = 1'b0;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_pending) begin
                        do_grant = 1'b1;
                        state_d  = PRESENT;
                    end
                end
                PRESENT: begin
                    if (ready) begin
                        do_grant = any_pending;
                        state_d  = any_pending ? PRESENT : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin : outputs
        valid    = (state_q == PRESENT);
        index    = index_q;
        pending  = pending_q;
        overflow = overflow_q;
    end

    always_comb begin : grant_decode
        grant_vec = '0;
        for (int i = 0; i < PULSE_COUNT; i++) begin
            grant_vec[i] = do_grant && (8'(i) == grant_idx);
        end
    end

    // A new pulse beats the grant of the same bit, so it is re-armed rather than lost.
    always_ff @(posedge clk or negedge rst_n) begin : datapath
        if (!rst_n) begin
            pending_q  <= '0;
            overflow_q <= '0;
            index_q    <= 8'hFF;
            last_q     <= '0;
        end else if (clear) begin
            pending_q  <= '0;
            overflow_q <= '0;
            last_q     <= '0;
        end else begin
            pending_q  <= (pending_q & ~grant_vec) | capture;
            overflow_q <= overflow_q | (capture & pending_q & ~grant_vec);
            if (do_grant) begin
                index_q <= grant_idx;
                last_q  <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_pulse_arbiter.sv
// Directed vector table plus randomized run against a queue-style reference model.
module tb_pulse_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] pulses = '0;
    logic [N-1:0] mask = '0;
    logic         clear = 1'b0;
    logic         ready = 1'b0;
    logic         valid;
    logic [7:0]   index;
    logic [N-1:0] pending;
    logic [N-1:0] overflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pulse_arbiter #(.PULSE_COUNT(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pulses   (pulses),
        .mask     (mask),
        .clear    (clear),
        .valid    (valid),
        .ready    (ready),
        .index    (index),
        .pending  (pending),
        .overflow (overflow)
    );

    // Reference model: pending/overflow as bit arrays, presented event as a flag + number.
    bit m_valid;
    int m_idx;
    int m_last;
    bit m_pend [N];
    bit m_ovf  [N];

    function automatic logic [N-1:0] pend_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [N-1:0] ovf_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_ovf[i];
        return v;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 255;
        m_last  = 0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_ovf[i]  = 1'b0;
        end
    endtask

    task automatic model_step(input logic [N-1:0] p, input logic [N-1:0] mk,
                              input logic r, input logic clr);
        bit old [N];
        bit any;
        int g;
        if (clr) begin
            m_valid = 1'b0;
            m_last  = 0;
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 1'b0;
                m_ovf[i]  = 1'b0;
            end
            return;
        end
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            old[i] = m_pend[i];
            any    = any | old[i];
        end
        g = -1;
        if (any && (!m_valid || r)) begin
            for (int k = 1; k <= N; k++) begin
                int cand;
                cand = (((m_last - k) % N) + N) % N;
                if (old[cand]) begin
                    g = cand;
                    break;
                end
            end
        end
        if (g >= 0) begin
            m_valid = 1'b1;
            m_idx   = g;
            m_last  = g;
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (p[i] && mk[i]) begin
                if (old[i] && i != g) m_ovf[i] = 1'b1;
                m_pend[i] = 1'b1;
            end else if (i == g) begin
                m_pend[i] = 1'b0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic [N-1:0] p, input logic [N-1:0] mk,
                        input logic r, input logic clr);
        @(negedge clk);
        pulses = p;
        mask   = mk;
        ready  = r;
        clear  = clr;
        @(posedge clk);
        model_step(p, mk, r, clr);
        #1;
    endtask

    typedef struct {
        logic [N-1:0] p;
        logic [N-1:0] mk;
        logic         r;
        logic         c;
        logic         ev;
        logic [7:0]   ei;
        logic [N-1:0] ep;
        logic [N-1:0] eo;
    } vec_t;

    localparam int NV = 36;
    vec_t tbl [NV];

    initial begin
        // single event
        tbl[0]  = '{4'b0100, 4'hF, 1'b1, 1'b0, 1'b0, 8'hFF, 4'b0100, 4'b0000};
        tbl[1]  = '{4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 8'd2,  4'b0000, 4'b0000};
        tbl[2]  = '{4'b0000, 4'hF, 1'b1, 1'b0, 1'b0, 8'd2,  4'b0000, 4'b0000};
        // clear restores last=0, then round-robin 3,2,1,0 and 1001 -> 3,0
        tbl[3]  = '{4'b0000, 4'hF, 1'b1, 1'b1, 1'b0, 8'd2,  4'b0000, 4'b0000};
        tbl[4]  = '{4'b1111, 4'hF, 1'b1, 1'b0, 1'b0, 8'd2,  4'b1111, 4'b0000};
        tbl[5]  = '{4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 8'd3,  4'b0111, 4'b0000};
        tbl[6]  = '{4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 8'd2,  4'b0011, 4'b0000};
        tbl[7]  = '{4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 8'd1,  4'b0001, 4'b0000};
        tbl[8]  = '{4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 8'd0,  4'b0000, 4'b0000};
        tbl[9]  = '{4'b1001, 4'hF, 1'b1, 1'b0, 1'b0, 8'd0,  4'b1001, 4'b0000};
        tbl[10] = '{4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 8'd3,  4'b0001, 4'b0000};
        tbl[11] = '{4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 8'd0,  4'b0000, 4'b0000};
        tbl[12] = '{4'b0000, 4'hF, 1'b1, 1'b0, 1'b0, 8'd0,  4'b0000, 4'b0000};
        // backpressure and overflow on source 1
        tbl[13] = '{4'b0010, 4'hF, 1'b0, 1'b0, 1'b0, 8'd0,  4'b0010, 4'b0000};
        tbl[14] = '{4'b0000, 4'hF, 1'b0, 1'b0, 1'b1, 8'd1,  4'b0000, 4'b0000};
        tbl[15] = '{4'b0000, 4'hF, 1'b0, 1'b0, 1'b1, 8'd1,  4'b0000, 4'b0000};
        tbl[16] = '{4'b0010, 4'hF, 1'b0, 1'b0, 1'b1, 8'd1,  4'b0010, 4'b0000};
        tbl[17] = '{4'b0000, 4'hF, 1'b0, 1'b0, 1'b1, 8'd1,  4'b0010, 4'b0000};
        tbl[18] = '{4'b0010, 4'hF, 1'b0, 1'b0, 1'b1, 8'd1,  4'b0010, 4'b0010};
        tbl[19] = '{4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 8'd1,  4'b0000, 4'b0010};
        tbl[20] = '{4'b0000, 4'hF, 1'b1, 1'b0, 1'b0, 8'd1,  4'b0000, 4'b0010};
        // collision on the grant edge, then a masked pulse
        tbl[21] = '{4'b0000, 4'hF, 1'b1, 1'b1, 1'b0, 8'd1,  4'b0000, 4'b0000};
        tbl[22] = '{4'b0001, 4'hF, 1'b1, 1'b0, 1'b0, 8'd1,  4'b0001, 4'b0000};
        tbl[23] = '{4'b0001, 4'hF, 1'b1, 1'b0, 1'b1, 8'd0,  4'b0001, 4'b0000};
        tbl[24] = '{4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 8'd0,  4'b0000, 4'b0000};
        tbl[25] = '{4'b0000, 4'hF, 1'b1, 1'b0, 1'b0, 8'd0,  4'b0000, 4'b0000};
        tbl[26] = '{4'b0001, 4'hE, 1'b1, 1'b0, 1'b0, 8'd0,  4'b0000, 4'b0000};
        tbl[27] = '{4'b0000, 4'hF, 1'b1, 1'b0, 1'b0, 8'd0,  4'b0000, 4'b0000};
        // build valid=1, pending=0110, overflow=0001, then clear over a handshake
        tbl[28] = '{4'b0010, 4'hF, 1'b0, 1'b0, 1'b0, 8'd0,  4'b0010, 4'b0000};
        tbl[29] = '{4'b0000, 4'hF, 1'b0, 1'b0, 1'b1, 8'd1,  4'b0000, 4'b0000};
        tbl[30] = '{4'b0001, 4'hF, 1'b0, 1'b0, 1'b1, 8'd1,  4'b0001, 4'b0000};
        tbl[31] = '{4'b0001, 4'hF, 1'b0, 1'b0, 1'b1, 8'd1,  4'b0001, 4'b0001};
        tbl[32] = '{4'b0110, 4'hF, 1'b1, 1'b0, 1'b1, 8'd0,  4'b0110, 4'b0001};
        tbl[33] = '{4'b1000, 4'hF, 1'b1, 1'b1, 1'b0, 8'd0,  4'b0000, 4'b0000};
        tbl[34] = '{4'b0011, 4'hF, 1'b0, 1'b0, 1'b0, 8'd0,  4'b0011, 4'b0000};
        tbl[35] = '{4'b0000, 4'hF, 1'b0, 1'b0, 1'b1, 8'd1,  4'b0001, 4'b0000};

        model_reset();
        #12;
        check("reset.valid", 32'(valid), 32'd0);
        check("reset.index", 32'(index), 32'hFF);
        check("reset.pending", 32'(pending), 32'd0);
        check("reset.overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < NV; v++) begin
            tick(tbl[v].p, tbl[v].mk, tbl[v].r, tbl[v].c);
            check($sformatf("vec%0d.valid", v), 32'(valid), 32'(tbl[v].ev));
            check($sformatf("vec%0d.index", v), 32'(index), 32'(tbl[v].ei));
            check($sformatf("vec%0d.pending", v), 32'(pending), 32'(tbl[v].ep));
            check($sformatf("vec%0d.overflow", v), 32'(overflow), 32'(tbl[v].eo));
        end

        // asynchronous reset in the middle of the high phase, no clock edge involved
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst.valid", 32'(valid), 32'd0);
        check("async_rst.index", 32'(index), 32'hFF);
        check("async_rst.pending", 32'(pending), 32'd0);
        check("async_rst.overflow", 32'(overflow), 32'd0);
        model_reset();
        @(negedge clk);
        pulses = '0;
        mask   = '1;
        ready  = 1'b0;
        clear  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [N-1:0] p;
            logic [N-1:0] mk;
            logic         r;
            logic         c;
            p  = N'($urandom) & N'($urandom);
            mk = ($urandom_range(0, 7) == 0) ? N'($urandom) : {N{1'b1}};
            r  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 99) == 0);
            tick(p, mk, r, c);
            check("rand.valid", 32'(valid), 32'(m_valid));
            check("rand.index", 32'(index), 32'(m_idx));
            check("rand.pending", 32'(pending), 32'(pend_vec()));
            check("rand.overflow", 32'(overflow), 32'(ovf_vec()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
